// File: rtl/key_scancode_fifo.sv
// Keyboard scancode FIFO: captures one entry per KEY_INTRPT pulse, first-word fall-through read side.
// Define KEY_SCANCODE_FIFO_E0_DROP_EN to discard the 8'hE0 extended prefix instead of storing it.
module key_scancode_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     KEY_INTRPT,
   input  logic [7:0]               KEY_SCANCODE,
   input  logic                     RD_EN,
   input  logic                     CLR_OVF,
   output logic [7:0]               DOUT,
   output logic                     EMPTY,
   output logic                     FULL,
   output logic [$clog2(DEPTH):0]   COUNT,
   output logic                     OVERFLOW,
   output logic                     IRQ
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   typedef enum logic {ARMED, WAIT_LOW} state_t;

   state_t          state;
   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count, count_nxt;
   logic            empty, full, overflow;
   logic            capture, push_req, do_push, do_pop, ovf_event;

   assign capture = (state == ARMED) && KEY_INTRPT;
`ifdef KEY_SCANCODE_FIFO_E0_DROP_EN
   assign push_req = capture && (KEY_SCANCODE != 8'hE0);
`else
   assign push_req = capture;
`endif

   // A pop at FULL frees the slot the simultaneous push lands in.
   assign do_pop    = RD_EN && !empty;
   assign do_push   = push_req && (!full || do_pop);
   assign ovf_event = push_req && full && !do_pop;

   always_comb begin
      count_nxt = count;
      case ({do_push, do_pop})
         2'b10:   count_nxt = count + CNT_ONE;
         2'b01:   count_nxt = count - CNT_ONE;
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state    <= ARMED;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         empty    <= 1'b1;
         full     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            ARMED:    if (KEY_INTRPT)  state <= WAIT_LOW;
            WAIT_LOW: if (!KEY_INTRPT) state <= ARMED;
            default:  state <= ARMED;
         endcase
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         count <= count_nxt;
         empty <= (count_nxt == '0);
         full  <= (count_nxt == FULL_CNT);
         if (ovf_event)    overflow <= 1'b1;
         else if (CLR_OVF) overflow <= 1'b0;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge CLK) begin
      if (do_push && !RESET) mem[wr_ptr] <= KEY_SCANCODE;
   end

   assign DOUT     = empty ? '0 : mem[rd_ptr];
   assign EMPTY    = empty;
   assign FULL     = full;
   assign COUNT    = count;
   assign OVERFLOW = overflow;
   assign IRQ      = ~empty;

endmodule

// File: tb/tb_key_scancode_fifo.sv
// Directed self-checking bench for key_scancode_fifo (DEPTH=8).
module tb_key_scancode_fifo;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       KEY_INTRPT = 1'b0;
   logic [7:0] KEY_SCANCODE = '0;
   logic       RD_EN = 1'b0;
   logic       CLR_OVF = 1'b0;
   logic [7:0] DOUT;
   logic       EMPTY, FULL, OVERFLOW, IRQ;
   logic [3:0] COUNT;

   int checks = 0;
   int errors = 0;

   key_scancode_fifo #(.DEPTH(8)) dut (
      .CLK(CLK), .RESET(RESET), .KEY_INTRPT(KEY_INTRPT), .KEY_SCANCODE(KEY_SCANCODE),
      .RD_EN(RD_EN), .CLR_OVF(CLR_OVF), .DOUT(DOUT), .EMPTY(EMPTY), .FULL(FULL),
      .COUNT(COUNT), .OVERFLOW(OVERFLOW), .IRQ(IRQ)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // 9-cycle pulse; rd_at/clr_at select the pulse cycle carrying RD_EN/CLR_OVF (-1 = none).
   task automatic pulse(input logic [7:0] code, input int rd_at, input int clr_at);
      KEY_SCANCODE = code;
      for (int c = 0; c < 9; c++) begin
         KEY_INTRPT = 1'b1;
         RD_EN      = (c == rd_at);
         CLR_OVF    = (c == clr_at);
         @(negedge CLK);
      end
      KEY_INTRPT = 1'b0;
      RD_EN      = 1'b0;
      CLR_OVF    = 1'b0;
      @(negedge CLK);
   endtask

   task automatic pop();
      RD_EN = 1'b1;
      @(negedge CLK);
      RD_EN = 1'b0;
   endtask

   task automatic clr();
      CLR_OVF = 1'b1;
      @(negedge CLK);
      CLR_OVF = 1'b0;
   endtask

   initial begin
      logic [7:0] exp_code;
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
      check("rst_count", COUNT, 0);
      check("rst_empty", EMPTY, 1);
      check("rst_full", FULL, 0);
      check("rst_ovf", OVERFLOW, 0);
      check("rst_irq", IRQ, 0);
      check("rst_dout", DOUT, 8'h00);

      // single pulse: entry visible one cycle after pulse start, only one entry
      KEY_SCANCODE = 8'h1C;
      KEY_INTRPT = 1'b1;
      @(negedge CLK);
      check("p1_count", COUNT, 1);
      check("p1_dout", DOUT, 8'h1C);
      check("p1_irq", IRQ, 1);
      repeat (8) @(negedge CLK);
      KEY_INTRPT = 1'b0;
      repeat (2) @(negedge CLK);
      check("p1_count_end", COUNT, 1);
      pop();
      check("p1_empty", EMPTY, 1);

      // ordered reads and pop on empty
      pulse(8'h1C, -1, -1);
      pulse(8'h32, -1, -1);
      pulse(8'h21, -1, -1);
      check("seq_count", COUNT, 3);
      check("seq_d0", DOUT, 8'h1C); pop();
      check("seq_d1", DOUT, 8'h32); pop();
      check("seq_d2", DOUT, 8'h21); pop();
      check("seq_empty", EMPTY, 1);
      check("seq_dout0", DOUT, 8'h00);
      pop();
      check("seq_pop_empty", COUNT, 0);

      // overflow, clear, and clear coincident with a new overflow
      for (int i = 1; i <= 9; i++) pulse(8'(i), -1, -1);
      check("ovf_full", FULL, 1);
      check("ovf_count", COUNT, 8);
      check("ovf_flag", OVERFLOW, 1);
      clr();
      check("ovf_clr", OVERFLOW, 0);
      pulse(8'h0A, -1, 0);
      check("ovf_clr_coincide", OVERFLOW, 1);
      clr();
      check("ovf_clr2", OVERFLOW, 0);
      for (int i = 1; i <= 8; i++) begin
         check("ovf_read", DOUT, 32'(i));
         pop();
      end
      check("ovf_drained", EMPTY, 1);

      // push and pop together at FULL
      for (int i = 1; i <= 8; i++) pulse(8'(i), -1, -1);
      pulse(8'h55, 0, -1);
      check("fpp_count", COUNT, 8);
      check("fpp_full", FULL, 1);
      check("fpp_ovf", OVERFLOW, 0);
      for (int i = 2; i <= 8; i++) begin
         check("fpp_read", DOUT, 32'(i));
         pop();
      end
      check("fpp_last", DOUT, 8'h55);
      pop();
      check("fpp_empty", EMPTY, 1);

      // push and pop together at EMPTY: push only
      pulse(8'h3C, 0, -1);
      check("epp_count", COUNT, 1);
      check("epp_dout", DOUT, 8'h3C);

      // pointer wrap: 20 simultaneous push/pop with one entry resident
      for (int i = 1; i <= 20; i++) begin
         exp_code = 8'(8'h40 + i);
         pulse(exp_code, 0, -1);
         check("wrap_count", COUNT, 1);
         check("wrap_dout", DOUT, exp_code);
      end
      pop();
      check("wrap_empty", EMPTY, 1);

      // extended prefix handling
      pulse(8'hE0, -1, -1);
      pulse(8'h75, -1, -1);
`ifdef KEY_SCANCODE_FIFO_E0_DROP_EN
      check("e0_count", COUNT, 1);
      check("e0_dout", DOUT, 8'h75);
      pop();
`else
      check("e0_count", COUNT, 2);
      check("e0_dout", DOUT, 8'hE0);
      pop();
      pop();
`endif
      check("e0_empty", EMPTY, 1);

      // reset mid-pulse with 3 entries stored
      pulse(8'h11, -1, -1);
      pulse(8'h12, -1, -1);
      pulse(8'h13, -1, -1);
      KEY_SCANCODE = 8'h2B;
      KEY_INTRPT = 1'b1;
      repeat (3) @(negedge CLK);
      check("mr_count_pre", COUNT, 4);
      RESET = 1'b1;
      @(negedge CLK);
      check("mr_count_rst", COUNT, 0);
      check("mr_ovf_rst", OVERFLOW, 0);
      check("mr_empty_rst", EMPTY, 1);
      RESET = 1'b0;
      @(negedge CLK);
      check("mr_recapture", COUNT, 1);
      check("mr_dout", DOUT, 8'h2B);
      repeat (4) @(negedge CLK);
      KEY_INTRPT = 1'b0;
      repeat (2) @(negedge CLK);
      check("mr_single", COUNT, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
